// File: rtl/if_inst_buffer.sv
// Fetch-result FIFO between if3 and decode: pairs the if3 bus with SRAM read data,
// holds fetched words across decode stalls, and requests a fetch stall before it can overflow.
module if_inst_buffer #(
  parameter int FS_TO_DS_BUS_WD  = 34,
  parameter int BUF_TO_DS_BUS_WD = 66,
  parameter int DEPTH            = 4,
  parameter int INFLIGHT         = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic                        br_taken,
  input  logic                        ds_stall,
  input  logic [FS_TO_DS_BUS_WD-1:0]  fs3_to_buf_bus,
  input  logic [31:0]                 inst_sram_rdata,
  output logic [BUF_TO_DS_BUS_WD-1:0] buf_to_ds_bus,
  output logic                        buf_stall_req,
  output logic                        buf_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = BUF_TO_DS_BUS_WD - 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_TH_C = CNT_W'(DEPTH - INFLIGHT);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic             kill_s, push_s, pop_s, full_s, wr_en_s, ovf_set_s;
  logic [ENT_W-1:0] entry_s;

  // An address-error fetch never carries SRAM data into decode.
  assign entry_s = {fs3_to_buf_bus[32], fs3_to_buf_bus[31:0],
                    fs3_to_buf_bus[32] ? 32'h0000_0000 : inst_sram_rdata};

  assign kill_s    = flush | br_taken;
  assign full_s    = (count_q == DEPTH_C);
  assign push_s    = fs3_to_buf_bus[33] & ~kill_s;
  assign pop_s     = (count_q != {CNT_W{1'b0}}) & ~ds_stall & ~kill_s;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
  assign wr_en_s   = push_s & (~full_s | pop_s);
  assign ovf_set_s = push_s & ~pop_s & full_s;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (kill_s) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      else         wr_ptr_d = wr_ptr_q;
      if (pop_s)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      else         rd_ptr_d = rd_ptr_q;
      case ({wr_en_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (ovf_set_s) ovf_d = 1'b1;
      else           ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {ENT_W{1'b0}};
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  assign buf_to_ds_bus = {count_q != {CNT_W{1'b0}}, mem_q[rd_ptr_q]};
  // Suppressed during a redirect: the stall controller must not hold the new fetch.
  assign buf_stall_req = ~kill_s & (count_q >= STALL_TH_C);
  assign buf_overflow  = ovf_q;

endmodule

// File: tb/tb_if_inst_buffer.sv
// Scoreboard bench for if_inst_buffer: a queue models the FIFO contents and is
// compared against the decode-side head, stall request and overflow flag.
module tb_if_inst_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush, br_taken, ds_stall;
  logic [33:0] fs3_to_buf_bus;
  logic [31:0] inst_sram_rdata;
  logic [65:0] buf_to_ds_bus;
  logic        buf_stall_req, buf_overflow;

  logic [65:0] exp_q[$];
  logic        exp_ovf;
  int          n_tests = 0;
  int          n_fail  = 0;

  if_inst_buffer #(.FS_TO_DS_BUS_WD(34), .BUF_TO_DS_BUS_WD(66), .DEPTH(4), .INFLIGHT(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .br_taken(br_taken), .ds_stall(ds_stall),
    .fs3_to_buf_bus(fs3_to_buf_bus), .inst_sram_rdata(inst_sram_rdata),
    .buf_to_ds_bus(buf_to_ds_bus), .buf_stall_req(buf_stall_req), .buf_overflow(buf_overflow)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, sample the stall request mid-cycle, update the model, cross the edge.
  task automatic cycle(input logic v, input logic a, input logic [31:0] pc, input logic [31:0] rd,
                       input logic st, input logic fl, input logic br,
                       output logic obs_req, output logic exp_req);
    logic kill, pop, full;
    fs3_to_buf_bus  = {v, a, pc};
    inst_sram_rdata = rd;
    ds_stall        = st;
    flush           = fl;
    br_taken        = br;
    kill    = fl | br;
    exp_req = !kill && (exp_q.size() >= 2);
    #3;
    obs_req = buf_stall_req;
    if (kill) begin
      exp_q.delete();
    end else begin
      pop  = (exp_q.size() != 0) && !st;
      full = (exp_q.size() == 4);
      if (v && full && !pop) exp_ovf = 1'b1;
      if (pop) void'(exp_q.pop_front());
      if (v && (!full || pop)) exp_q.push_back({1'b1, a, pc, a ? 32'h0 : rd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if (buf_to_ds_bus !== 66'h0) begin
      n_fail++; $display("FAIL reset_bus actual=%h required=%h", buf_to_ds_bus, 66'h0);
    end
    n_tests++;
    if (buf_stall_req !== 1'b0 || buf_overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags actual=%b%b required=00", buf_stall_req, buf_overflow);
    end
  endtask

  task automatic test_in_order();
    logic [31:0] pcs [3];
    logic [31:0] rds [3];
    logic [65:0] e;
    logic ro, re;
    pcs[0] = 32'h1c00_0000; pcs[1] = 32'h1c00_0004; pcs[2] = 32'h1c00_0008;
    rds[0] = 32'h0000_0011; rds[1] = 32'h0000_0022; rds[2] = 32'h0000_0033;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, pcs[i], rds[i], 1'b0, 1'b0, 1'b0, ro, re);
      e = {1'b1, 1'b0, pcs[i], rds[i]};
      n_tests++;
      if (buf_to_ds_bus !== e) begin
        n_fail++; $display("FAIL in_order_%0d actual=%h required=%h", i, buf_to_ds_bus, e);
      end
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, ro, re);
    n_tests++;
    if (buf_to_ds_bus[65] !== 1'b0) begin
      n_fail++; $display("FAIL in_order_drain actual=%b required=0", buf_to_ds_bus[65]);
    end
  endtask

  task automatic test_stall_fill();
    logic ro, re;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'h1c00_0000 + 32'(4 * i), 32'h0000_00a0 + 32'(i), 1'b1, 1'b0, 1'b0, ro, re);
      n_tests++;
      if (ro !== (i >= 2) || ro !== re) begin
        n_fail++; $display("FAIL stall_req_%0d actual=%b required=%b", i, ro, (i >= 2));
      end
      n_tests++;
      if (buf_to_ds_bus[65:32] !== {1'b1, 1'b0, 32'h1c00_0000}) begin
        n_fail++; $display("FAIL stall_head_%0d actual=%h required=%h", i, buf_to_ds_bus[65:32], {2'b10, 32'h1c00_0000});
      end
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, ro, re);
    n_tests++;
    if (ro !== 1'b1 || buf_overflow !== 1'b0 || exp_q.size() != 4) begin
      n_fail++; $display("FAIL stall_full actual=req%b ovf%b required=req1 ovf0", ro, buf_overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic ro, re;
    logic [65:0] e;
    cycle(1'b1, 1'b0, 32'h1c00_0010, 32'h0000_0055, 1'b0, 1'b0, 1'b0, ro, re);
    n_tests++;
    if (buf_to_ds_bus[63:32] !== 32'h1c00_0004 || buf_overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_pushpop actual=pc%h ovf%b required=pc1c000004 ovf0", buf_to_ds_bus[63:32], buf_overflow);
    end
    for (int k = 0; k < 4; k++) begin
      e = (exp_q.size() != 0) ? exp_q[0] : 66'h0;
      n_tests++;
      if (buf_to_ds_bus !== e) begin
        n_fail++; $display("FAIL full_drain_%0d actual=%h required=%h", k, buf_to_ds_bus, e);
      end
      if (k == 3) begin
        n_tests++;
        if (buf_to_ds_bus !== {2'b10, 32'h1c00_0010, 32'h0000_0055}) begin
          n_fail++; $display("FAIL full_tail actual=%h required=%h", buf_to_ds_bus, {2'b10, 32'h1c00_0010, 32'h0000_0055});
        end
      end
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, ro, re);
    end
    n_tests++;
    if (buf_to_ds_bus[65] !== 1'b0) begin
      n_fail++; $display("FAIL full_empty actual=%b required=0", buf_to_ds_bus[65]);
    end
  endtask

  task automatic test_redirect();
    logic ro, re;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 32'h1c00_0100 + 32'(4 * i), 32'h0000_0070 + 32'(i), 1'b1, 1'b0, 1'b0, ro, re);
    cycle(1'b1, 1'b0, 32'h1c00_010c, 32'h0000_0077, 1'b0, 1'b0, 1'b1, ro, re);
    n_tests++;
    if (ro !== 1'b0) begin
      n_fail++; $display("FAIL br_stall_forced actual=%b required=0", ro);
    end
    n_tests++;
    if (buf_to_ds_bus[65] !== 1'b0) begin
      n_fail++; $display("FAIL br_valid actual=%b required=0", buf_to_ds_bus[65]);
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, ro, re);
    n_tests++;
    if (ro !== 1'b0 || buf_to_ds_bus[65] !== 1'b0) begin
      n_fail++; $display("FAIL br_lost actual=req%b valid%b required=req0 valid0", ro, buf_to_ds_bus[65]);
    end
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 1'b0, 32'h1c00_0180 + 32'(4 * i), 32'h0000_0080, 1'b1, 1'b0, 1'b0, ro, re);
    cycle(1'b1, 1'b0, 32'h1c00_0188, 32'h0000_0088, 1'b1, 1'b1, 1'b0, ro, re);
    n_tests++;
    if (buf_to_ds_bus[65] !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL flush_valid actual=%b required=0", buf_to_ds_bus[65]);
    end
  endtask

  task automatic test_adef();
    logic ro, re;
    cycle(1'b1, 1'b1, 32'h1c00_0002, 32'hdead_beef, 1'b0, 1'b0, 1'b0, ro, re);
    n_tests++;
    if (buf_to_ds_bus !== {1'b1, 1'b1, 32'h1c00_0002, 32'h0000_0000} || buf_to_ds_bus !== exp_q[0]) begin
      n_fail++; $display("FAIL adef actual=%h required=%h", buf_to_ds_bus, {2'b11, 32'h1c00_0002, 32'h0});
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, ro, re);
  endtask

  task automatic test_overflow_async_reset();
    logic ro, re;
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 32'h1c00_0200 + 32'(4 * i), 32'h0000_0090 + 32'(i), 1'b1, 1'b0, 1'b0, ro, re);
    n_tests++;
    if (buf_overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_early actual=%b required=0", buf_overflow);
    end
    cycle(1'b1, 1'b0, 32'h1c00_0210, 32'h0000_0099, 1'b1, 1'b0, 1'b0, ro, re);
    n_tests++;
    if (buf_overflow !== 1'b1 || buf_overflow !== exp_ovf || buf_to_ds_bus !== exp_q[0]) begin
      n_fail++; $display("FAIL ovf_set actual=ovf%b head%h required=ovf1 head%h", buf_overflow, buf_to_ds_bus, exp_q[0]);
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, ro, re);
    n_tests++;
    if (buf_overflow !== 1'b1 || buf_to_ds_bus[65] !== 1'b0) begin
      n_fail++; $display("FAIL ovf_sticky actual=ovf%b valid%b required=ovf1 valid0", buf_overflow, buf_to_ds_bus[65]);
    end
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 1'b0, 32'h1c00_0300 + 32'(4 * i), 32'h0000_00c0, 1'b1, 1'b0, 1'b0, ro, re);
    n_tests++;
    if (buf_to_ds_bus[65] !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_valid actual=%b required=1", buf_to_ds_bus[65]);
    end
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if (buf_to_ds_bus !== 66'h0 || buf_stall_req !== 1'b0 || buf_overflow !== 1'b0) begin
      n_fail++; $display("FAIL async_reset actual=bus%h req%b ovf%b required=0", buf_to_ds_bus, buf_stall_req, buf_overflow);
    end
    exp_q.delete();
    exp_ovf = 1'b0;
    @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 32'h1c00_0400, 32'h0000_00d0, 1'b0, 1'b0, 1'b0, ro, re);
    n_tests++;
    if (buf_to_ds_bus !== {2'b10, 32'h1c00_0400, 32'h0000_00d0} || buf_to_ds_bus !== exp_q[0]) begin
      n_fail++; $display("FAIL post_reset actual=%h required=%h", buf_to_ds_bus, {2'b10, 32'h1c00_0400, 32'h0000_00d0});
    end
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; br_taken = 1'b0; ds_stall = 1'b0;
    fs3_to_buf_bus = 34'h0; inst_sram_rdata = 32'h0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    test_in_order();
    test_stall_fill();
    test_full_push_pop();
    test_redirect();
    test_adef();
    test_overflow_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
